// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets,
// reset constants and the byte-lane write merge.
package clint_pkg;

  localparam logic [15:0] MSIP_OFS        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFS = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFS = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFS    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFS    = 16'hBFFC;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MTIME_RST    = 64'h0000_0000_0000_0000;

  // Replace only the byte lanes whose enable is set; other lanes keep old.
  function automatic logic [31:0] apply_mask(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  lane_en);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (lane_en[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/clint_timer.sv
// Machine timer: prescaler plus 64-bit mtime counter with a per-half
// byte-masked write port. A write to mtime wins over that cycle's tick,
// while the prescaler itself never pauses.
module clint_timer
  import clint_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  output logic [63:0] mtime
);

  localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);

  logic [15:0] pre_cnt;
  logic        tick;

  assign tick = (pre_cnt == PS_MAX);

  // Prescaler: free-running 0..PRESCALE-1, tick on the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 16'd1;
    end
  end

  // mtime: software write overrides the increment; halves written independently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime <= MTIME_RST;
    end else if (wr_en) begin
      if (wr_hi) begin
        mtime[63:32] <= apply_mask(mtime[63:32], wr_data, wr_be);
      end else begin
        mtime[31:0] <= apply_mask(mtime[31:0], wr_data, wr_be);
      end
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

endmodule

// File: rtl/lsu_clint.sv
// Core-local interruptor on the LSU req/res port. Decodes msip, mtimecmp
// and mtime, returns a fixed one-cycle response, and drives the software
// and timer interrupt lines.
module lsu_clint
  import clint_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_from_lsu,
  input  logic        load_from_lsu,
  input  logic        store_from_lsu,
  input  logic [31:0] addr_from_lsu,
  input  logic [31:0] store_result_from_lsu,
  input  logic [4:0]  store_mask_from_lsu,
  output logic        res_to_lsu,
  output logic [31:0] data_to_lsu,
  output logic        soft_irq,
  output logic        time_irq
);

  logic [15:0] ofs_p0;
  logic        sel_msip_p0;
  logic        sel_cmp_lo_p0;
  logic        sel_cmp_hi_p0;
  logic        sel_time_lo_p0;
  logic        sel_time_hi_p0;
  logic        wr_p0;
  logic        rd_p0;
  logic [3:0]  be_p0;
  logic [31:0] rdata_p0;

  logic        msip_q;
  logic [63:0] mtimecmp_q;
  logic [63:0] mtime;

  logic        vld_p1;
  logic [31:0] rdata_p1;
  logic        irq_p1;

  logic        unused_bits;

  // Request stage: word-aligned decode of the low 16 address bits.
  assign ofs_p0         = {addr_from_lsu[15:2], 2'b00};
  assign sel_msip_p0    = (ofs_p0 == MSIP_OFS);
  assign sel_cmp_lo_p0  = (ofs_p0 == MTIMECMP_LO_OFS);
  assign sel_cmp_hi_p0  = (ofs_p0 == MTIMECMP_HI_OFS);
  assign sel_time_lo_p0 = (ofs_p0 == MTIME_LO_OFS);
  assign sel_time_hi_p0 = (ofs_p0 == MTIME_HI_OFS);
  assign be_p0          = store_mask_from_lsu[3:0];

  // Store wins when both qualifiers are set; a store never returns data.
  assign wr_p0 = req_from_lsu & store_from_lsu;
  assign rd_p0 = req_from_lsu & load_from_lsu & ~store_from_lsu;

  assign unused_bits = ^{addr_from_lsu[31:16], addr_from_lsu[1:0], store_mask_from_lsu[4]};

  // Read mux over the pre-edge register state; unmapped offsets read 0.
  always_comb begin
    rdata_p0 = '0;
    if (sel_msip_p0) begin
      rdata_p0 = {31'd0, msip_q};
    end else if (sel_cmp_lo_p0) begin
      rdata_p0 = mtimecmp_q[31:0];
    end else if (sel_cmp_hi_p0) begin
      rdata_p0 = mtimecmp_q[63:32];
    end else if (sel_time_lo_p0) begin
      rdata_p0 = mtime[31:0];
    end else if (sel_time_hi_p0) begin
      rdata_p0 = mtime[63:32];
    end
  end

  clint_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_p0 & (sel_time_lo_p0 | sel_time_hi_p0)),
    .wr_hi   (sel_time_hi_p0),
    .wr_data (store_result_from_lsu),
    .wr_be   (be_p0),
    .mtime   (mtime)
  );

  // msip: only bit 0 is backed by storage, written through lane 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msip_q <= 1'b0;
    end else if (wr_p0 && sel_msip_p0 && be_p0[0]) begin
      msip_q <= store_result_from_lsu[0];
    end
  end

  // mtimecmp: two independent byte-masked 32-bit halves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtimecmp_q <= MTIMECMP_RST;
    end else if (wr_p0 && sel_cmp_lo_p0) begin
      mtimecmp_q[31:0] <= apply_mask(mtimecmp_q[31:0], store_result_from_lsu, be_p0);
    end else if (wr_p0 && sel_cmp_hi_p0) begin
      mtimecmp_q[63:32] <= apply_mask(mtimecmp_q[63:32], store_result_from_lsu, be_p0);
    end
  end

  // Response stage: one-cycle res pulse with data zeroed unless a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1   <= req_from_lsu;
      rdata_p1 <= rd_p0 ? rdata_p0 : 32'd0;
    end
  end

  // Timer interrupt: registered compare of the current register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_p1 <= 1'b0;
    end else begin
      irq_p1 <= (mtime >= mtimecmp_q);
    end
  end

  assign res_to_lsu  = vld_p1;
  assign data_to_lsu = rdata_p1;
  assign time_irq    = irq_p1;
  assign soft_irq    = msip_q;

endmodule

// File: doc/lsu_clint.md
# lsu_clint

Memory-mapped core-local interruptor that answers the LSU load/store port with the same req/res handshake the itcm and dtcm blocks use. It owns the 64-bit machine timer (mtime), its compare register (mtimecmp) and the software-interrupt bit (msip). It drives the `time_irq` and `soft_irq` inputs of core_top. It is instantiated in cpu_top beside the TCMs; the LSU's address decoder steers `req` to it.

## Interface
- `PRESCALE`, default 1: clk cycles per mtime increment; legal range is 1 to 65535.
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous assert, active low
- `req_from_lsu`  in  1  access request; single-cycle pulse per access
- `load_from_lsu`  in  1  read qualifier, valid with `req`
- `store_from_lsu`  in  1  write qualifier, valid with `req`
- `addr_from_lsu`  in  32  byte address; only [15:0] is decoded
- `store_result_from_lsu`  in  32  write data, lane-aligned
- `store_mask_from_lsu`  in  5  [3:0] are byte-lane enables; [4] is ignored
- `res_to_lsu`  out  1  response pulse
- `data_to_lsu`  out  32  read data, valid while `res_to_lsu` is high
- `soft_irq`  out  1  equals msip[0]
- `time_irq`  out  1  asserted while mtime >= mtimecmp

## Operation
- Register map (offset = addr[15:0], word aligned; addr[1:0] ignored):
  - 0x0000 msip: only bit 0 is writable; bits [31:1] read 0.
  - 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32].
  - 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
- Unmapped offsets read 0 and ignore writes. A response is still returned.
- Reset values:
  - mtime = 0; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; msip = 0; prescale counter = 0.
  - `res_to_lsu` = 0, `data_to_lsu` = 0, `time_irq` = 0, `soft_irq` = 0.
- Store: each byte lane with its mask bit set is written; other lanes are kept.
  - A mask of 4'b0000 writes nothing but still gets a response.
  - The two 32-bit halves of each 64-bit register are independent. No carry or borrow crosses halves on a write.
- Load: returns the register value as it stood in the request cycle, before that cycle's increment or write.
- If `store` and `load` are both set with `req`, the access is a store and the read data is 0.
- If `req` is high with neither `store` nor `load` set, a response is returned with data 0.
- Prescaler: counts 0 to PRESCALE-1. The cycle in which it equals PRESCALE-1 is a tick; the counter then returns to 0 and mtime increments by 1.
- mtime wraps from 2^64-1 to 0 without an interrupt side effect.
- Write/tick collision on the same cycle:
  - A store to either mtime half takes priority; mtime takes the written value and the increment for that cycle is dropped.
  - The prescaler keeps running.
- `time_irq` is a registered unsigned 64-bit compare of mtime >= mtimecmp. It is level-sensitive, stays high until software raises mtimecmp or rewrites mtime, and has no latching.

## Timing
- Fixed 1-cycle response: `req` sampled high at edge N gives `res_to_lsu` = 1 for exactly the cycle after edge N, with `data_to_lsu` valid in that cycle.
- Back-to-back `req` on every cycle is accepted; there is no busy or stall signal.
- `data_to_lsu` is 0 whenever `res_to_lsu` is 0.
- A store takes effect at the same edge that samples `req`.
- `soft_irq` follows msip with 0 cycles of delay after the write edge, since it is a direct register output.
- `time_irq` reflects the register state after edge N at edge N+1. It is therefore one cycle behind any mtime or mtimecmp change.
- Reset asserted mid-access: any pending `res_to_lsu` is dropped immediately and every register takes its reset value. No response is owed after reset.

## Structure
- Shared package `clint_pkg`:
  - offset localparams MSIP_OFS, MTIMECMP_LO/HI_OFS, MTIME_LO/HI_OFS;
  - reset constants MTIMECMP_RST and MTIME_RST;
  - a function that applies byte-lane masking.
- Sub-module `clint_timer` holds the prescaler, the 64-bit mtime counter and the write-override port (32-bit data, 4-bit lane enables, half select).
- The top level holds the bus decode, msip, mtimecmp, the response register and the compare flop.

## Test plan
- Reset with PRESCALE=1, hold 10 cycles, load 0xBFF8 → `res_to_lsu` one cycle after `req`; data equals the cycle count since reset release; `time_irq` = 0.
- Store 0x0000 = 32'h1 with mask 4'hF → `soft_irq` = 1 from the next edge. Store with mask 4'hE → `soft_irq` stays 1. Store 0 with mask 4'h1 → `soft_irq` = 0.
- Store mtimecmp hi = 0, then lo = 20 → `time_irq` rises exactly one cycle after mtime reads 20. Store mtimecmp lo = 0xFFFF_FFFF → `time_irq` falls one cycle later.
- Store mtime = {32'hFFFF_FFFF, 32'hFFFF_FFFE} with PRESCALE=4 → mtime = 0 after 8 more cycles; hi half reads 0.
- Store mtime lo in the same cycle as a tick → the read-back equals the written value, not the written value + 1.
- Back-to-back loads to 0x4000, 0x1234, 0xBFFC → three consecutive `res_to_lsu` cycles with data 0xFFFF_FFFF, 0, then the mtime hi value. Assert `rst_n` low during the second response → `res_to_lsu` drops immediately.
